// File: rtl/reset_sequencer.sv
// ============================================================================
// Module   : reset_sequencer
// Brief    : Lock-qualified, index-ordered release of active-low domain resets
// Revision : 1.0
// ============================================================================
`default_nettype none

module reset_sequencer #(
  parameter int NUM_OUT     = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rstn_async,
  input  logic               pll_lock,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] rstn_out,
  output logic               rst_done
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_e;

  logic [1:0]         sync_q;
  logic               sw_prev_q;
  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [IW-1:0]      idx_q;
  logic [NUM_OUT-1:0] rstn_out_q;
  logic               rst_done_q;
  logic               sw_rst_ack_q;
  logic               rst_sync;
  logic               sw_req;

  // Async assert, sync deassert: the FSM leaves reset on the 2nd edge after release.
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      sync_q    <= 2'b00;
      sw_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], 1'b1};
      sw_prev_q <= sw_rst_req;
    end
  end

  assign rst_sync = sync_q[1];
  assign sw_req   = sw_rst_req & ~sw_prev_q;

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      idx_q        <= '0;
      rstn_out_q   <= '0;
      rst_done_q   <= 1'b0;
      sw_rst_ack_q <= 1'b0;
    end else if (!rst_sync) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      idx_q        <= '0;
      rstn_out_q   <= '0;
      rst_done_q   <= 1'b0;
      sw_rst_ack_q <= 1'b0;
    end else begin
      // An accepted request is acknowledged even when lock loss wins the same edge.
      sw_rst_ack_q <= sw_req;
      if (!pll_lock || sw_req) begin
        state_q    <= S_HOLD;
        cnt_q      <= '0;
        idx_q      <= '0;
        rstn_out_q <= '0;
        rst_done_q <= 1'b0;
      end else begin
        case (state_q)
          S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              rstn_out_q[0] <= 1'b1;
              cnt_q         <= '0;
              if (NUM_OUT == 1) begin
                idx_q      <= '0;
                rst_done_q <= 1'b1;
                state_q    <= S_RUN;
              end else begin
                idx_q   <= IW'(1);
                state_q <= S_RELEASE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_RELEASE: begin
            if (cnt_q == GAP_LAST) begin
              for (int i = 0; i < NUM_OUT; i++) begin
                if (idx_q == IW'(i)) begin
                  rstn_out_q[i] <= 1'b1;
                end
              end
              cnt_q <= '0;
              if (idx_q == LAST_IDX) begin
                idx_q      <= '0;
                rst_done_q <= 1'b1;
                state_q    <= S_RUN;
              end else begin
                idx_q <= idx_q + IW'(1);
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_RUN: begin
            state_q <= S_RUN;
          end
          default: begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            rstn_out_q <= '0;
            rst_done_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rstn_out   = rstn_out_q;
  assign rst_done   = rst_done_q;
  assign sw_rst_ack = sw_rst_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Directed self-checking bench for reset_sequencer (default and minimal params)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

  logic       clk;
  logic       rstn_async;
  logic       pll_lock;
  logic       sw_rst_req;
  logic       sw_rst_ack;
  logic [2:0] rstn_out;
  logic       rst_done;
  logic       sw_rst_ack1;
  logic [0:0] rstn_out1;
  logic       rst_done1;

  int vectors;
  int miscompares;

  reset_sequencer #(.NUM_OUT(3), .HOLD_CYCLES(16), .GAP_CYCLES(4)) dut (
    .clk        (clk),
    .rstn_async (rstn_async),
    .pll_lock   (pll_lock),
    .sw_rst_req (sw_rst_req),
    .sw_rst_ack (sw_rst_ack),
    .rstn_out   (rstn_out),
    .rst_done   (rst_done)
  );

  reset_sequencer #(.NUM_OUT(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .clk        (clk),
    .rstn_async (rstn_async),
    .pll_lock   (pll_lock),
    .sw_rst_req (sw_rst_req),
    .sw_rst_ack (sw_rst_ack1),
    .rstn_out   (rstn_out1),
    .rst_done   (rst_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs k edges after HOLD entry with lock steady (16/4 timing).
  function automatic logic [2:0] exp_rstn(input int k);
    logic [2:0] v;
    for (int i = 0; i < 3; i++) v[i] = (k >= 16 + i * 4);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse rstn_async and stop at HOLD entry (2nd edge after release).
  task automatic enter_hold();
    @(negedge clk);
    rstn_async = 1'b0;
    repeat (3) @(negedge clk);
    rstn_async = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    rstn_async = 1'b0;
    pll_lock   = 1'b1;
    sw_rst_req = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (rstn_out !== 3'b000 || rst_done !== 1'b0 || sw_rst_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: rstn_out=%b done=%b ack=%b, need 000/0/0",
               rstn_out, rst_done, sw_rst_ack);
    end
    rstn_async = 1'b1;
    step();
    step();
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 15 || k == 16 || k == 19 || k == 20 || k == 23 || k == 24) begin
        vectors++;
        if (rstn_out !== exp_rstn(k) || rst_done !== (k >= 24)) begin
          miscompares++;
          $display("FAIL powerup_k%0d: rstn_out=%b done=%b, need %b/%b",
                   k, rstn_out, rst_done, exp_rstn(k), (k >= 24));
        end
      end
    end
  endtask

  task automatic test_lock_glitch();
    enter_hold();
    for (int k = 1; k <= 34; k++) begin
      if (k == 10) pll_lock = 1'b0;
      step();
      pll_lock = 1'b1;
      if (k == 16 || k == 25 || k == 26 || k == 29 || k == 30 || k == 34) begin
        vectors++;
        if (rstn_out !== exp_rstn(k - 10) || rst_done !== (k >= 34)) begin
          miscompares++;
          $display("FAIL glitch_k%0d: rstn_out=%b done=%b, need %b/%b",
                   k, rstn_out, rst_done, exp_rstn(k - 10), (k >= 34));
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    vectors++;
    if (rstn_out !== 3'b000 || rst_done !== 1'b0 || sw_rst_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL lockloss_edge: rstn_out=%b done=%b ack=%b, need 000/0/0",
               rstn_out, rst_done, sw_rst_ack);
    end
    for (int k = 1; k <= 24; k++) begin
      step();
      vectors++;
      if (rstn_out !== exp_rstn(k) || rst_done !== (k >= 24) || sw_rst_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL lockloss_k%0d: rstn_out=%b done=%b ack=%b, need %b/%b/0",
                 k, rstn_out, rst_done, sw_rst_ack, exp_rstn(k), (k >= 24));
      end
    end
  endtask

  task automatic test_sw_request();
    for (int p = 0; p < 2; p++) begin
      sw_rst_req = 1'b1;
      step();
      vectors++;
      if (rstn_out !== 3'b000 || rst_done !== 1'b0 || sw_rst_ack !== 1'b1) begin
        miscompares++;
        $display("FAIL swreq%0d_edge: rstn_out=%b done=%b ack=%b, need 000/0/1",
                 p, rstn_out, rst_done, sw_rst_ack);
      end
      for (int k = 1; k <= 50; k++) begin
        step();
        vectors++;
        if (rstn_out !== exp_rstn(k) || rst_done !== (k >= 24) || sw_rst_ack !== 1'b0) begin
          miscompares++;
          $display("FAIL swreq%0d_k%0d: rstn_out=%b done=%b ack=%b, need %b/%b/0",
                   p, k, rstn_out, rst_done, sw_rst_ack, exp_rstn(k), (k >= 24));
        end
      end
      sw_rst_req = 1'b0;
      step();
      step();
      vectors++;
      if (rstn_out !== 3'b111 || sw_rst_ack !== 1'b0) begin
        miscompares++;
        $display("FAIL swreq%0d_low: rstn_out=%b ack=%b, need 111/0",
                 p, rstn_out, sw_rst_ack);
      end
    end
  endtask

  task automatic test_async_mid_release();
    enter_hold();
    for (int k = 1; k <= 17; k++) step();
    vectors++;
    if (rstn_out !== 3'b001) begin
      miscompares++;
      $display("FAIL midrel_pre: rstn_out=%b, need 001", rstn_out);
    end
    #2;
    rstn_async = 1'b0;
    #1;
    vectors++;
    if (rstn_out !== 3'b000 || rst_done !== 1'b0 || sw_rst_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL midrel_async: rstn_out=%b done=%b ack=%b, need 000/0/0",
               rstn_out, rst_done, sw_rst_ack);
    end
    enter_hold();
    for (int k = 1; k <= 24; k++) begin
      step();
      vectors++;
      if (rstn_out !== exp_rstn(k) || rst_done !== (k >= 24)) begin
        miscompares++;
        $display("FAIL midrel_k%0d: rstn_out=%b done=%b, need %b/%b",
                 k, rstn_out, rst_done, exp_rstn(k), (k >= 24));
      end
    end
  endtask

  task automatic test_min_params();
    enter_hold();
    vectors++;
    if (rstn_out1 !== 1'b0 || rst_done1 !== 1'b0) begin
      miscompares++;
      $display("FAIL min_k0: rstn_out=%b done=%b, need 0/0", rstn_out1, rst_done1);
    end
    step();
    vectors++;
    if (rstn_out1 !== 1'b1 || rst_done1 !== 1'b1) begin
      miscompares++;
      $display("FAIL min_k1: rstn_out=%b done=%b, need 1/1", rstn_out1, rst_done1);
    end
    step();
    vectors++;
    if (rstn_out1 !== 1'b1 || rst_done1 !== 1'b1) begin
      miscompares++;
      $display("FAIL min_k2: rstn_out=%b done=%b, need 1/1", rstn_out1, rst_done1);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_lock_glitch();
    test_lock_loss();
    test_sw_request();
    test_async_mid_release();
    test_min_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
